// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated edge counter: counts sig_in rising edges over a programmable clk window
`timescale 1ns/1ps

module freq_meter #(
    parameter int WIDTH      = 32,
    // Gate counter width; follows WIDTH unless a narrow count needs a longer window.
    parameter int GATE_WIDTH = WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sig_in,
    input  logic                  start,
    input  logic [GATE_WIDTH-1:0] gate_len,
    input  logic                  ack,
    output logic [WIDTH-1:0]      count,
    output logic                  valid,
    output logic                  busy,
    output logic                  overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                state, state_nx;

    logic                  sync1, sync2, sync3;
    logic                  rise_det;

    logic [GATE_WIDTH-1:0] gate_cnt;
    logic [WIDTH-1:0]      edge_cnt, edge_nx;
    logic                  ovf_acc, ovf_nx;

    logic                  accept;
    logic                  gate_zero;
    logic                  last_cycle;

    // sync1/sync2 resolve metastability; sync3 is the previous sample for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise_det = sync2 & ~sync3;

    always_comb begin
        accept     = start && ((state == IDLE) || ((state == DONE) && ack));
        gate_zero  = (gate_len == '0);
        last_cycle = (state == MEASURE) && (gate_cnt == GATE_WIDTH'(1));

        // Saturating increment; a rise at full scale only flags overflow.
        edge_nx = edge_cnt;
        ovf_nx  = ovf_acc;
        if ((state == MEASURE) && rise_det) begin
            if (&edge_cnt) begin
                ovf_nx = 1'b1;
            end else begin
                edge_nx = edge_cnt + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = gate_zero ? DONE : MEASURE;
                end
            end
            MEASURE: begin
                if (last_cycle) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (ack) begin
                    if (accept) begin
                        state_nx = gate_zero ? DONE : MEASURE;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // count/overflow change only when a result completes, so they stay readable after ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf_acc  <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            gate_cnt <= gate_len;
            edge_cnt <= '0;
            ovf_acc  <= 1'b0;
            if (gate_zero) begin
                count    <= '0;
                overflow <= 1'b0;
            end
        end else if (state == MEASURE) begin
            gate_cnt <= gate_cnt - GATE_WIDTH'(1);
            edge_cnt <= edge_nx;
            ovf_acc  <= ovf_nx;
            if (last_cycle) begin
                count    <= edge_nx;
                overflow <= ovf_nx;
            end
        end
    end

    assign valid = (state == DONE);
    assign busy  = (state == MEASURE);

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - scoreboard bench for freq_meter
`timescale 1ns/100ps

module tb_freq_meter;

    logic        clk;
    logic        rst;
    logic        sig_in;
    logic        start;
    logic [31:0] gate_len;
    logic        ack;
    logic [31:0] count;
    logic        valid;
    logic        busy;
    logic        overflow;

    logic        start4;
    logic [7:0]  gate_len4;
    logic        ack4;
    logic [3:0]  count4;
    logic        valid4;
    logic        busy4;
    logic        overflow4;

    int          checks;
    int          errors;
    int          sig_period;
    int          ph;
    int          n;
    logic        valid_seen;

    typedef struct {
        logic [31:0] cnt;
        logic        ovf;
    } exp_t;

    exp_t q[$];
    exp_t q4[$];

    freq_meter #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .sig_in   (sig_in),
        .start    (start),
        .gate_len (gate_len),
        .ack      (ack),
        .count    (count),
        .valid    (valid),
        .busy     (busy),
        .overflow (overflow)
    );

    freq_meter #(.WIDTH(4), .GATE_WIDTH(8)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .sig_in   (sig_in),
        .start    (start4),
        .gate_len (gate_len4),
        .ack      (ack4),
        .count    (count4),
        .valid    (valid4),
        .busy     (busy4),
        .overflow (overflow4)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // sig_in generator: period in clk cycles, 0 holds the line low
    initial begin
        sig_in = 1'b0;
        ph     = 0;
        forever begin
            @(negedge clk);
            if (sig_period == 0) begin
                sig_in = 1'b0;
                ph     = 0;
            end else begin
                ph     = (ph + 1) % sig_period;
                sig_in = (ph < sig_period / 2);
            end
        end
    end

    initial begin : monitor_main
        logic pv;
        exp_t e;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (valid && !pv) begin
                    valid_seen = 1'b1;
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid: count=%0d overflow=%0d", count, overflow);
                    end else begin
                        e = q.pop_front();
                        chk("result_count", count, e.cnt);
                        chk("result_overflow", 32'(overflow), 32'(e.ovf));
                    end
                end
                pv = valid;
            end
        end
    end

    initial begin : monitor_w4
        logic pv;
        exp_t e;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (valid4 && !pv) begin
                    if (q4.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid4: count=%0d overflow=%0d", count4, overflow4);
                    end else begin
                        e = q4.pop_front();
                        chk("w4_count", 32'(count4), e.cnt);
                        chk("w4_overflow", 32'(overflow4), 32'(e.ovf));
                    end
                end
                pv = valid4;
            end
        end
    end

    // Counts busy cycles from the current negedge until valid, bounded.
    task automatic measure_busy(output int cnt);
        cnt = 0;
        for (int i = 0; i < 400 && !valid; i++) begin
            if (busy) cnt++;
            @(negedge clk);
        end
        chk("valid_after_window", 32'(valid), 32'd1);
    endtask

    task automatic pulse_start(input logic [31:0] len);
        start    = 1'b1;
        gate_len = len;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("valid_after_ack", 32'(valid), 32'd0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        sig_period = 0;
        valid_seen = 1'b0;
        rst        = 1'b1;
        start      = 1'b0;
        gate_len   = '0;
        ack        = 1'b0;
        start4     = 1'b0;
        gate_len4  = '0;
        ack4       = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_count", count, 32'd0);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);

        // 80-cycle window, period 8, start on the first edge after release
        rst        = 1'b0;
        sig_period = 8;
        q.push_back('{32'd10, 1'b0});
        pulse_start(32'd80);
        chk("first_start_busy", 32'(busy), 32'd1);
        measure_busy(n);
        chk("busy_len_80", 32'(n), 32'd80);

        // start without ack in DONE is ignored
        pulse_start(32'd5);
        chk("done_start_valid", 32'(valid), 32'd1);
        chk("done_start_busy", 32'(busy), 32'd0);
        chk("done_start_count", count, 32'd10);
        pulse_ack();
        chk("count_held_after_ack", count, 32'd10);

        // sig_in held low
        sig_period = 0;
        repeat (6) @(negedge clk);
        q.push_back('{32'd0, 1'b0});
        pulse_start(32'd50);
        measure_busy(n);
        chk("busy_len_50", 32'(n), 32'd50);
        pulse_ack();
        chk("count_zero_after_ack", count, 32'd0);

        // zero-length gate straight to DONE
        sig_period = 4;
        repeat (6) @(negedge clk);
        q.push_back('{32'd0, 1'b0});
        pulse_start(32'd0);
        chk("gate0_valid", 32'(valid), 32'd1);
        chk("gate0_busy", 32'(busy), 32'd0);

        // ack+start together in DONE, 16-cycle window, period 4; mid-window start ignored
        ack      = 1'b1;
        start    = 1'b1;
        gate_len = 32'd16;
        q.push_back('{32'd4, 1'b0});
        @(negedge clk);
        ack   = 1'b0;
        start = 1'b0;
        chk("ackstart_busy", 32'(busy), 32'd1);
        chk("ackstart_valid", 32'(valid), 32'd0);
        n = 0;
        for (int i = 0; i < 400 && !valid; i++) begin
            if (busy) n++;
            if (i == 5) begin
                start    = 1'b1;
                gate_len = 32'd3;
            end
            if (i == 6) start = 1'b0;
            @(negedge clk);
        end
        chk("busy_len_16", 32'(n), 32'd16);
        pulse_ack();

        // reset in the middle of an 80-cycle window
        sig_period = 8;
        pulse_start(32'd80);
        repeat (29) @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #0.3 rst = 1'b1;
        #0.2;
        chk("abort_count", count, 32'd0);
        chk("abort_valid", 32'(valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_overflow", 32'(overflow), 32'd0);
        sig_period = 0;
        repeat (3) @(negedge clk);
        rst        = 1'b0;
        valid_seen = 1'b0;
        repeat (100) @(negedge clk);
        chk("no_valid_after_abort", 32'(valid_seen), 32'd0);
        sig_period = 8;
        q.push_back('{32'd10, 1'b0});
        pulse_start(32'd80);
        measure_busy(n);
        chk("busy_len_after_abort", 32'(n), 32'd80);
        pulse_ack();

        // WIDTH=4: 20 edges saturate at 15
        sig_period = 2;
        repeat (6) @(negedge clk);
        q4.push_back('{32'd15, 1'b1});
        start4    = 1'b1;
        gate_len4 = 8'd40;
        @(negedge clk);
        start4 = 1'b0;
        for (int i = 0; i < 200 && !valid4; i++) @(negedge clk);
        chk("w4_valid", 32'(valid4), 32'd1);
        ack4 = 1'b1;
        @(negedge clk);
        ack4 = 1'b0;
        chk("w4_valid_after_ack", 32'(valid4), 32'd0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        chk("scoreboard4_drained", 32'(q4.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
